sdio_dat_rx: RTL

Receives read-data blocks from the card on the DAT lines. It supports a 1-bit or 4-bit bus, checks a CRC16 per lane and the end bit, and pushes assembled bytes into the host read FIFO. It sits beside the command engine: `dat_rx_start` is driven by the command engine's `cmd_tx_end`. It shares the clock-control `rx_en` sample strobe and reports status and error events to the register block.

---
 rtl/sdio_pkg.sv | 27 ++
 rtl/sdio_crc16.sv | 34 +++
 rtl/sdio_dat_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sdio_pkg.sv
// Shared SDIO definitions: DAT receive state encodings, CRC16 length and
// the serial CCITT CRC16 step used by every lane.
package sdio_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitStart = 3'd1,
        StRxData    = 3'd2,
        StRxCrc     = 3'd3,
        StRxEnd     = 3'd4
    } dat_rx_state_e;

    localparam int unsigned SDIO_CRC16_LEN    = 16;
    localparam int unsigned SDIO_DAT_RX_TMOUT = 64;
    localparam int unsigned SDIO_DAT_CNT_W    = 15;

    // One serial step of x^16 + x^12 + x^5 + 1.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic [15:0] nxt;
        nxt = {crc[14:0], 1'b0};
        if (crc[15] ^ din) begin
            nxt = nxt ^ 16'h1021;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sdio_crc16.sv
// Serial CCITT CRC16 accumulator for one DAT lane; cleared to zero by crc_rst.
module sdio_crc16
    import sdio_pkg::*;
(
    input  logic        sd_clk,
    input  logic        rstn,
    input  logic        crc_rst,
    input  logic        crc_din_en,
    input  logic        crc_din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (crc_rst) begin
            crc_d = '0;
        end else if (crc_din_en) begin
            crc_d = crc16_step(crc_q, crc_din);
        end
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sdio_dat_rx.sv
// SDIO DAT-line block receiver: 1/4-bit bus, per-lane CRC16 and end-bit checks,
// byte assembly into the host read FIFO.
module sdio_dat_rx
    import sdio_pkg::*;
#(
    parameter int unsigned TMOUT_CNT  = SDIO_DAT_RX_TMOUT,
    parameter int unsigned BLK_SIZE_W = 12
) (
    input  logic                  sd_clk,
    input  logic                  rstn,
    input  logic                  sd_rst,
    input  logic                  bus_width_4,
    input  logic [BLK_SIZE_W-1:0] blk_size,
    input  logic [15:0]           blk_cnt,
    input  logic                  dat_rx_start,
    input  logic                  rx_en,
    input  logic [3:0]            dat_i,
    input  logic                  fifo_full,
    output logic [7:0]            fifo_wdata,
    output logic                  fifo_wen,
    output logic                  dat_rx_busy,
    output logic                  dat_rx_done,
    output logic                  blk_rx_end,
    output logic                  dat_timeout_err_event,
    output logic                  dat_crc_err_event,
    output logic                  dat_end_err_event,
    output logic                  dat_ovr_err_event,
    output logic [2:0]            dat_rx_fsm
);

    localparam int unsigned CntW     = SDIO_DAT_CNT_W;
    localparam logic [7:0]  TmoutVal = 8'(TMOUT_CNT);

    dat_rx_state_e     state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [15:0]       blk_q, blk_d;
    logic [7:0]        tmout_q, tmout_d;
    logic [7:0]        sr_q, sr_d;
    logic [7:0]        fifo_wdata_q, fifo_wdata_d;
    logic              fifo_wen_q, fifo_wen_d;
    logic [3:0][15:0]  rcv_q, rcv_d;
    logic [3:0][15:0]  crc;

    logic [3:0]            lane_en, crc_din_en, crc_mism;
    logic                  crc_clr, start_seen, byte_done, rx_end;
    logic [BLK_SIZE_W-1:0] blk_size_eff;
    logic [CntW-1:0]       size_ext, beats_m1;
    logic [7:0]            tmout_inc;
    logic [15:0]           blk_dec;

    assign lane_en      = bus_width_4 ? 4'hF : 4'h1;
    assign blk_size_eff = (blk_size == '0) ? BLK_SIZE_W'(1) : blk_size;
    assign size_ext     = CntW'(blk_size_eff);
    assign beats_m1     = bus_width_4 ? (size_ext << 1) - CntW'(1) : (size_ext << 3) - CntW'(1);
    assign tmout_inc    = (tmout_q == 8'hFF) ? 8'hFF : tmout_q + 8'd1;
    assign blk_dec      = blk_q - 16'd1;

    assign start_seen = rx_en && (state_q == StWaitStart) && !dat_i[0];
    assign rx_end     = rx_en && (state_q == StRxEnd);
    // The beat counter's low bits mark byte boundaries since it counts down from a multiple of 8/2.
    assign byte_done  = rx_en && (state_q == StRxData) &&
                        (bus_width_4 ? (cnt_q[0] == 1'b0) : (cnt_q[2:0] == 3'd0));

    assign crc_clr    = start_seen || sd_rst;
    assign crc_din_en = lane_en & {4{rx_en && (state_q == StRxData)}};

    for (genvar l = 0; l < 4; l++) begin : g_lane
        sdio_crc16 u_crc16 (
            .sd_clk     (sd_clk),
            .rstn       (rstn),
            .crc_rst    (crc_clr),
            .crc_din_en (crc_din_en[l]),
            .crc_din    (dat_i[l]),
            .crc        (crc[l])
        );
        assign crc_mism[l] = lane_en[l] && ({rcv_q[l][14:0], dat_i[l]} != crc[l]);
    end

    assign dat_timeout_err_event = rx_en && (state_q == StWaitStart) && dat_i[0] &&
                                   (tmout_inc == TmoutVal);
    assign dat_crc_err_event     = rx_en && (state_q == StRxCrc) && (cnt_q == '0) && (|crc_mism);
    assign dat_end_err_event     = rx_end && (|(lane_en & ~dat_i));
    assign dat_ovr_err_event     = byte_done && fifo_full;
    assign blk_rx_end            = rx_end;
    assign dat_rx_done           = rx_end && (blk_dec == 16'd0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blk_d        = blk_q;
        tmout_d      = tmout_q;
        sr_d         = sr_q;
        rcv_d        = rcv_q;
        fifo_wdata_d = fifo_wdata_q;
        fifo_wen_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dat_rx_start) begin
                    state_d = StWaitStart;
                    blk_d   = (blk_cnt == 16'd0) ? 16'd1 : blk_cnt;
                    tmout_d = '0;
                end
            end
            StWaitStart: begin
                if (rx_en) begin
                    if (!dat_i[0]) begin
                        state_d = StRxData;
                        cnt_d   = beats_m1;
                    end else begin
                        tmout_d = tmout_inc;
                        if (tmout_inc == TmoutVal) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StRxData: begin
                if (rx_en) begin
                    sr_d = bus_width_4 ? {sr_q[3:0], dat_i} : {sr_q[6:0], dat_i[0]};
                    if (byte_done && !fifo_full) begin
                        fifo_wdata_d = sr_d;
                        fifo_wen_d   = 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_d = StRxCrc;
                        cnt_d   = CntW'(SDIO_CRC16_LEN - 1);
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StRxCrc: begin
                if (rx_en) begin
                    for (int l = 0; l < 4; l++) begin
                        if (lane_en[l]) begin
                            rcv_d[l] = {rcv_q[l][14:0], dat_i[l]};
                        end
                    end
                    if (cnt_q == '0) begin
                        state_d = StRxEnd;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StRxEnd: begin
                if (rx_en) begin
                    blk_d = blk_dec;
                    if (blk_dec != 16'd0) begin
                        state_d = StWaitStart;
                        tmout_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (sd_rst) begin
            state_d      = StIdle;
            cnt_d        = '0;
            blk_d        = '0;
            tmout_d      = '0;
            sr_d         = '0;
            rcv_d        = '0;
            fifo_wdata_d = '0;
            fifo_wen_d   = 1'b0;
        end
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            blk_q        <= '0;
            tmout_q      <= '0;
            sr_q         <= '0;
            rcv_q        <= '0;
            fifo_wdata_q <= '0;
            fifo_wen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blk_q        <= blk_d;
            tmout_q      <= tmout_d;
            sr_q         <= sr_d;
            rcv_q        <= rcv_d;
            fifo_wdata_q <= fifo_wdata_d;
            fifo_wen_q   <= fifo_wen_d;
        end
    end

    assign fifo_wdata  = fifo_wdata_q;
    assign fifo_wen    = fifo_wen_q;
    assign dat_rx_busy = (state_q != StIdle);
    assign dat_rx_fsm  = state_q;

endmodule
